au_result_fifo: RTL and testbench

- Downstream capture stage for the 8-bit arithmetic unit `topAU`.
- Registers each AU result together with its op select and its C/O/Z/E/G/L flags into a DEPTH-entry FIFO.
- Presents entries to the consumer with a valid/ready handshake.
- Keeps sticky carry and overflow status for software or a controller to poll and clear.

---
 rtl/au_result_fifo.sv | 134 +++++++++++++
 tb/tb_au_result_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/au_result_fifo.sv
// ============================================================================
// au_result_fifo: show-ahead result FIFO with sticky C/O status for topAU.
// Optional macro AU_DROP_CNT_EN enables the saturating rejected-write counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module au_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_s,
  input  logic             in_c,
  input  logic             in_o,
  input  logic             in_z,
  input  logic             in_e,
  input  logic             in_g,
  input  logic             in_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [7:0]       out_s,
  output logic [5:0]       out_flags,
  output logic [CNT_W-1:0] count,
  output logic             sticky_c,
  output logic             sticky_o,
  input  logic             sticky_clr,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last_slot = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_full_cnt  = CNT_W'(DEPTH);

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_sticky_c;
  logic             r_sticky_o;

  logic             w_wr;
  logic             w_rd;
  logic [15:0]      w_entry;
  logic [15:0]      w_head;

  assign in_ready  = (r_count != c_full_cnt);
  assign out_valid = (r_count != '0);
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;
  assign w_entry   = {in_op, in_c, in_o, in_z, in_e, in_g, in_l, in_s};
  assign w_head    = r_mem[r_rd_ptr];

  // Head fields are gated so an empty FIFO presents all-zero data.
  assign out_op    = out_valid ? w_head[15:14] : 2'b00;
  assign out_flags = out_valid ? w_head[13:8]  : 6'b000000;
  assign out_s     = out_valid ? w_head[7:0]   : 8'h00;
  assign count     = r_count;
  assign sticky_c  = r_sticky_c;
  assign sticky_o  = r_sticky_o;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_last_slot) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == c_last_slot) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // A set-causing write takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky_c <= 1'b0;
      r_sticky_o <= 1'b0;
    end else begin
      if (w_wr && in_c) begin
        r_sticky_c <= 1'b1;
      end else if (sticky_clr) begin
        r_sticky_c <= 1'b0;
      end
      if (w_wr && in_o) begin
        r_sticky_o <= 1'b1;
      end else if (sticky_clr) begin
        r_sticky_o <= 1'b0;
      end
    end
  end

`ifdef AU_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = in_valid && !in_ready;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'h00;
    end else if (sticky_clr) begin
      r_drop_cnt <= w_drop ? 8'h01 : 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_au_result_fifo.sv
// ============================================================================
// tb_au_result_fifo: directed stimulus with a queue scoreboard and head monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_au_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_s;
  logic       in_c, in_o, in_z, in_e, in_g, in_l;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [7:0] out_s;
  logic [5:0] out_flags;
  logic [2:0] count;
  logic       sticky_c, sticky_o, sticky_clr;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

`ifdef AU_DROP_CNT_EN
  localparam logic [7:0] c_exp_drop = 8'd3;
`else
  localparam logic [7:0] c_exp_drop = 8'd0;
`endif

  au_result_fifo #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_s(in_s),
    .in_c(in_c), .in_o(in_o), .in_z(in_z), .in_e(in_e), .in_g(in_g), .in_l(in_l),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_s(out_s),
    .out_flags(out_flags), .count(count), .sticky_c(sticky_c), .sticky_o(sticky_o),
    .sticky_clr(sticky_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Head monitor: every consumed entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL head: got %0h expected nothing (queue empty)", {out_op, out_s, out_flags});
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({out_op, out_s, out_flags} !== e) begin
          n_fail++;
          $display("FAIL head: got %0h expected %0h", {out_op, out_s, out_flags}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [7:0] s, input logic [5:0] f);
    in_op = op;
    in_s  = s;
    {in_c, in_o, in_z, in_e, in_g, in_l} = f;
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] s, input logic [5:0] f);
    set_in(op, s, f);
    in_valid = 1'b1;
    exp_q.push_back({op, s, f});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    set_in(2'b00, 8'h00, 6'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sticky", 32'({sticky_c, sticky_o}), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Single push / pop
    push(2'b00, 8'h30, 6'b000000);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_s", 32'(out_s), 32'h30);
    chk("t1_count", 32'(count), 32'd1);
    pop_n(1);
    chk("t1_empty_valid", 32'(out_valid), 32'd0);
    chk("t1_empty_s", 32'(out_s), 32'h00);
    chk("t1_empty_count", 32'(count), 32'd0);

    // Fill, refused write while full, drain in order
    for (int i = 1; i <= 4; i++) begin
      set_in(2'b01, 8'(i), 6'b000010);
      in_valid = 1'b1;
      exp_q.push_back({2'b01, 8'(i), 6'b000010});
      tick();
    end
    in_valid = 1'b0;
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    set_in(2'b01, 8'h05, 6'b110000);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t2_count_held", 32'(count), 32'd4);
    chk("t2_drop", 32'(drop_cnt), 32'(c_exp_drop));
    chk("t2_sticky_untouched", 32'({sticky_c, sticky_o}), 32'd0);
    pop_n(4);
    chk("t2_drained", 32'(count), 32'd0);

    // Streaming with wrap-around
    set_in(2'b10, 8'h10, 6'b001000);
    in_valid = 1'b1;
    exp_q.push_back({2'b10, 8'h10, 6'b001000});
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_in(2'b10, 8'h10 + 8'(i), 6'b001000);
      exp_q.push_back({2'b10, 8'h10 + 8'(i), 6'b001000});
      tick();
      chk("t3_count_steady", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("t3_drained", 32'(count), 32'd0);

    // Sticky bits
    push(2'b01, 8'h90, 6'b110000);
    chk("t4_sticky_set", 32'({sticky_c, sticky_o}), 32'b11);
    pop_n(1);
    chk("t4_sticky_after_pop", 32'({sticky_c, sticky_o}), 32'b11);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("t4_sticky_cleared", 32'({sticky_c, sticky_o}), 32'b00);
    chk("t4_drop_cleared", 32'(drop_cnt), 32'd0);
    sticky_clr = 1'b1;
    push(2'b10, 8'h91, 6'b010000);
    sticky_clr = 1'b0;
    chk("t4_set_wins", 32'({sticky_c, sticky_o}), 32'b01);
    pop_n(1);

    // Asynchronous reset mid-operation
    push(2'b00, 8'hA1, 6'b100000);
    push(2'b00, 8'hA2, 6'b100000);
    push(2'b00, 8'hA3, 6'b100000);
    chk("t5_count3", 32'(count), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_sticky", 32'({sticky_c, sticky_o}), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    push(2'b11, 8'hE8, 6'b000100);
    chk("t5_head_s", 32'(out_s), 32'hE8);
    chk("t5_head_op", 32'(out_op), 32'd3);
    chk("t5_count1", 32'(count), 32'd1);
    pop_n(1);

    // Full with simultaneous read: write refused, then accepted
    for (int i = 1; i <= 4; i++) begin
      push(2'b01, 8'hC0 + 8'(i), 6'b000001);
    end
    chk("t6_full", 32'(count), 32'd4);
    set_in(2'b01, 8'hC5, 6'b000001);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_no_bypass_count", 32'(count), 32'd3);
    chk("t6_ready_again", 32'(in_ready), 32'd1);
    exp_q.push_back({2'b01, 8'hC5, 6'b000001});
    tick();
    in_valid = 1'b0;
    chk("t6_accepted", 32'(count), 32'd4);
    pop_n(4);
    chk("t6_drained", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
